// File: rtl/alu_share_ctrl_if.sv
// Request/response bundle for the two-port shared ALU scheduler.
// Two requesters push operands and pull results here; busy/grant show ALU status.
interface alu_share_ctrl_if;
    logic        req0_valid_i;
    logic        req0_ready_o;
    logic [31:0] req0_src1_i;
    logic [31:0] req0_src2_i;
    logic [3:0]  req0_ctrl_i;
    logic        req1_valid_i;
    logic        req1_ready_o;
    logic [31:0] req1_src1_i;
    logic [31:0] req1_src2_i;
    logic [3:0]  req1_ctrl_i;
    logic        rsp0_valid_o;
    logic        rsp0_ready_i;
    logic [31:0] rsp0_result_o;
    logic        rsp0_zero_o;
    logic        rsp1_valid_o;
    logic        rsp1_ready_i;
    logic [31:0] rsp1_result_o;
    logic        rsp1_zero_o;
    logic        busy_o;
    logic        grant_o;

    modport slave (
        input  req0_valid_i, req0_src1_i, req0_src2_i, req0_ctrl_i,
        input  req1_valid_i, req1_src1_i, req1_src2_i, req1_ctrl_i,
        input  rsp0_ready_i, rsp1_ready_i,
        output req0_ready_o, req1_ready_o,
        output rsp0_valid_o, rsp0_result_o, rsp0_zero_o,
        output rsp1_valid_o, rsp1_result_o, rsp1_zero_o,
        output busy_o, grant_o
    );

    modport master (
        output req0_valid_i, req0_src1_i, req0_src2_i, req0_ctrl_i,
        output req1_valid_i, req1_src1_i, req1_src2_i, req1_ctrl_i,
        output rsp0_ready_i, rsp1_ready_i,
        input  req0_ready_o, req1_ready_o,
        input  rsp0_valid_o, rsp0_result_o, rsp0_zero_o,
        input  rsp1_valid_o, rsp1_result_o, rsp1_zero_o,
        input  busy_o, grant_o
    );
endinterface

// File: rtl/alu_share_ctrl.sv
// Round-robin scheduler sharing one combinational 32-bit ALU between two requesters.
// Ports: clk_i, rst_i (async, active-high), bus (alu_share_ctrl_if.slave).

// Team 32-bit combinational ALU.
module alu_core (
    input  logic [31:0] src1_i,
    input  logic [31:0] src2_i,
    input  logic [3:0]  ctrl_i,
    output logic [31:0] result_o,
    output logic        zero_o
);
    always_comb begin
        result_o = 32'h0;
        case (ctrl_i)
            4'b0000: result_o = src1_i & src2_i;
            4'b0001: result_o = src1_i | src2_i;
            4'b0010: result_o = src1_i + src2_i;
            4'b0111: result_o = {31'h0, src1_i < src2_i};
            4'b1000: result_o = {31'h0, $signed(src1_i) < $signed(src2_i)};
            4'b1001: result_o = $unsigned($signed(src2_i) >>> src1_i[4:0]);
            // Low half of a product is identical for signed and unsigned.
            4'b1010: result_o = src1_i * src2_i;
            4'b1011: result_o = {src2_i[15:0], 16'h0};
            default: result_o = 32'h0;
        endcase
    end

    assign zero_o = (result_o == 32'h0);
endmodule

module alu_share_ctrl #(
    parameter int unsigned MUL_LAT = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    alu_share_ctrl_if.slave   bus
);
    typedef enum logic {IDLE, EXEC} state_e;

    localparam logic [3:0] CTRL_MUL = 4'b1010;
    localparam logic [3:0] MUL_CNT  = 4'(MUL_LAT - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] src1_q, src1_d;
    logic [31:0] src2_q, src2_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic        owner_q, owner_d;
    logic        last_grant_q, last_grant_d;
    logic        grant_q, grant_d;
    logic        rsp0_valid_q, rsp0_valid_d;
    logic [31:0] rsp0_result_q, rsp0_result_d;
    logic        rsp0_zero_q, rsp0_zero_d;
    logic        rsp1_valid_q, rsp1_valid_d;
    logic [31:0] rsp1_result_q, rsp1_result_d;
    logic        rsp1_zero_q, rsp1_zero_d;

    logic        elig0, elig1, pick;
    logic        rdy0, rdy1;
    logic        supported;
    logic [31:0] alu_result, op_result;
    logic        alu_zero, op_zero;

    alu_core u_alu (
        .src1_i   (src1_q),
        .src2_i   (src2_q),
        .ctrl_i   (ctrl_q),
        .result_o (alu_result),
        .zero_o   (alu_zero)
    );

    always_comb begin
        supported = 1'b0;
        case (ctrl_q)
            4'b0000, 4'b0001, 4'b0010, 4'b0111,
            4'b1000, 4'b1001, 4'b1010, 4'b1011: supported = 1'b1;
            default: supported = 1'b0;
        endcase
    end

    assign op_result = supported ? alu_result : 32'h0;
    assign op_zero   = supported ? alu_zero : 1'b1;

    // A pending response blocks its owner; a same-cycle drain only
    // helps from the following cycle since the registered flag is used.
    assign elig0 = bus.req0_valid_i & ~rsp0_valid_q;
    assign elig1 = bus.req1_valid_i & ~rsp1_valid_q;
    assign pick  = (elig0 & elig1) ? ~last_grant_q : elig1;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        src1_d        = src1_q;
        src2_d        = src2_q;
        ctrl_d        = ctrl_q;
        owner_d       = owner_q;
        last_grant_d  = last_grant_q;
        grant_d       = grant_q;
        rsp0_valid_d  = rsp0_valid_q;
        rsp0_result_d = rsp0_result_q;
        rsp0_zero_d   = rsp0_zero_q;
        rsp1_valid_d  = rsp1_valid_q;
        rsp1_result_d = rsp1_result_q;
        rsp1_zero_d   = rsp1_zero_q;
        rdy0          = 1'b0;
        rdy1          = 1'b0;

        if (rsp0_valid_q && bus.rsp0_ready_i) rsp0_valid_d = 1'b0;
        if (rsp1_valid_q && bus.rsp1_ready_i) rsp1_valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (elig0 || elig1) begin
                    rdy0         = ~pick;
                    rdy1         = pick;
                    src1_d       = pick ? bus.req1_src1_i : bus.req0_src1_i;
                    src2_d       = pick ? bus.req1_src2_i : bus.req0_src2_i;
                    ctrl_d       = pick ? bus.req1_ctrl_i : bus.req0_ctrl_i;
                    owner_d      = pick;
                    last_grant_d = pick;
                    grant_d      = pick;
                    cnt_d        = (ctrl_d == CTRL_MUL) ? MUL_CNT : 4'h0;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == 4'h0) begin
                    state_d = IDLE;
                    if (owner_q) begin
                        rsp1_valid_d  = 1'b1;
                        rsp1_result_d = op_result;
                        rsp1_zero_d   = op_zero;
                    end else begin
                        rsp0_valid_d  = 1'b1;
                        rsp0_result_d = op_result;
                        rsp0_zero_d   = op_zero;
                    end
                end else begin
                    cnt_d = cnt_q - 4'h1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            cnt_q         <= 4'h0;
            src1_q        <= 32'h0;
            src2_q        <= 32'h0;
            ctrl_q        <= 4'h0;
            owner_q       <= 1'b0;
            last_grant_q  <= 1'b1;
            grant_q       <= 1'b0;
            rsp0_valid_q  <= 1'b0;
            rsp0_result_q <= 32'h0;
            rsp0_zero_q   <= 1'b0;
            rsp1_valid_q  <= 1'b0;
            rsp1_result_q <= 32'h0;
            rsp1_zero_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            src1_q        <= src1_d;
            src2_q        <= src2_d;
            ctrl_q        <= ctrl_d;
            owner_q       <= owner_d;
            last_grant_q  <= last_grant_d;
            grant_q       <= grant_d;
            rsp0_valid_q  <= rsp0_valid_d;
            rsp0_result_q <= rsp0_result_d;
            rsp0_zero_q   <= rsp0_zero_d;
            rsp1_valid_q  <= rsp1_valid_d;
            rsp1_result_q <= rsp1_result_d;
            rsp1_zero_q   <= rsp1_zero_d;
        end
    end

    assign bus.req0_ready_o  = rdy0;
    assign bus.req1_ready_o  = rdy1;
    assign bus.rsp0_valid_o  = rsp0_valid_q;
    assign bus.rsp0_result_o = rsp0_result_q;
    assign bus.rsp0_zero_o   = rsp0_zero_q;
    assign bus.rsp1_valid_o  = rsp1_valid_q;
    assign bus.rsp1_result_o = rsp1_result_q;
    assign bus.rsp1_zero_o   = rsp1_zero_q;
    assign bus.busy_o        = (state_q == EXEC);
    assign bus.grant_o       = grant_q;
endmodule
